// File: rtl/mul_div_unit.sv
// ----------------------------------------------------------------------------
// mul_div_unit
//
// Iterative integer multiply / divide unit with architectural HI/LO registers.
//
// Operations (selected by the 6-bit funct code on op, sampled with start):
//   MULT  / MULTU : 32x32 -> 64-bit product, hi = product[63:32], lo = [31:0]
//   DIV   / DIVU  : lo = quotient (truncated toward zero), hi = remainder
//                   (remainder carries the dividend's sign for DIV)
//   MTHI  / MTLO  : direct write of a into hi / lo, no busy, no done
//
// Arithmetic ops run for 32 cycles (one iteration per cycle) on operand
// magnitudes; the sign fix-up is applied on the final iteration, as hi/lo
// are written. Divide by zero is not trapped: it yields hi = a,
// lo = 0xFFFFFFFF after the full latency.
//
// Ports:
//   clk    in   1  clock, all state updates on the rising edge
//   reset  in   1  synchronous active-high reset
//   a      in  32  operand rs (dividend / multiplicand)
//   b      in  32  operand rt (divisor / multiplier)
//   op     in   6  funct code
//   start  in   1  request, honoured only while idle
//   busy   out  1  iterative operation in progress
//   done   out  1  one-cycle pulse: hi/lo hold a new result
//   hi     out 32  HI register
//   lo     out 32  LO register
//
// Build option:
//   MUL_DIV_UNIT_FAST_MULT_EN  when defined, MULT/MULTU finish in one cycle:
//                              the product is written on the accepting edge,
//                              done pulses in the next cycle and busy stays 0.
//                              DIV/DIVU keep the 32-cycle path.
// ----------------------------------------------------------------------------
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [5:0]  op,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    localparam logic [5:0] LAST_ITER = 6'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [5:0]  cnt_reg;
    // Shared 64-bit work register:
    //   multiply: {partial product high, remaining multiplier bits}
    //   divide  : {partial remainder, dividend bits / quotient bits}
    logic [63:0] acc_reg;
    // Magnitude of the multiplicand or the divisor.
    logic [31:0] m_reg;
    logic        is_div_reg;
    // Negate the product (multiply) or the quotient (divide) at the end.
    logic        neg_q_reg;
    // Negate the remainder at the end (signed divide, negative dividend).
    logic        neg_r_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic op_mul;
    logic op_div;
    logic op_signed;
    logic op_mthi;
    logic op_mtlo;
    logic idle_start;
    logic accept_run;

    assign op_mul     = (op == OP_MULT) || (op == OP_MULTU);
    assign op_div     = (op == OP_DIV)  || (op == OP_DIVU);
    assign op_signed  = (op == OP_MULT) || (op == OP_DIV);
    assign op_mthi    = (op == OP_MTHI);
    assign op_mtlo    = (op == OP_MTLO);
    assign idle_start = (state_reg == IDLE) && start;

`ifdef MUL_DIV_UNIT_FAST_MULT_EN
    logic               accept_fast;
    logic signed [63:0] fast_s;
    logic        [63:0] fast_u;
    logic        [63:0] fast_prod;

    assign accept_fast = idle_start && op_mul;
    assign accept_run  = idle_start && op_div;
    // Both operands signed, so the 64-bit context sign-extends them.
    assign fast_s      = $signed(a) * $signed(b);
    assign fast_u      = {32'd0, a} * {32'd0, b};
    assign fast_prod   = op_signed ? fast_s : fast_u;
`else
    assign accept_run  = idle_start && (op_mul || op_div);
`endif

    // Operand magnitudes; unsigned ops pass the raw value through.
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    assign a_mag = (op_signed && a[31]) ? (~a + 32'd1) : a;
    assign b_mag = (op_signed && b[31]) ? (~b + 32'd1) : b;

    // ------------------------------------------------------------------
    // One iteration of the datapath
    // ------------------------------------------------------------------
    logic [32:0] mul_sum;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] acc_step;

    always_comb begin
        mul_sum  = 33'd0;
        div_ge   = 1'b0;
        div_diff = 32'd0;
        acc_step = acc_reg;

        if (is_div_reg) begin
            // Restoring step: the shifted partial remainder is 33 bits wide
            // (acc_reg[63:31]); when it is >= divisor the difference is
            // below the divisor, so 32 bits hold it exactly.
            div_ge   = acc_reg[63:31] >= {1'b0, m_reg};
            div_diff = acc_reg[62:31] - m_reg;
            if (div_ge) begin
                acc_step = {div_diff, acc_reg[30:0], 1'b1};
            end else begin
                acc_step = {acc_reg[62:0], 1'b0};
            end
        end else begin
            // Shift-add: add the multiplicand into the upper half when the
            // current multiplier bit is set, then shift the pair right with
            // the carry entering at the top.
            mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, m_reg} : 33'd0);
            acc_step = {mul_sum, acc_reg[31:1]};
        end
    end

    // ------------------------------------------------------------------
    // Final sign correction, applied to the last iteration's output
    // ------------------------------------------------------------------
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        prod_fix = neg_q_reg ? (~acc_step + 64'd1) : acc_step;
        quo_fix  = neg_q_reg ? (~acc_step[31:0] + 32'd1) : acc_step[31:0];
        rem_fix  = neg_r_reg ? (~acc_step[63:32] + 32'd1) : acc_step[63:32];
        if (is_div_reg) begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end else begin
            res_hi = prod_fix[63:32];
            res_lo = prod_fix[31:0];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept_run) begin
                    state_next = RUN;
                end
`ifdef MUL_DIV_UNIT_FAST_MULT_EN
                else if (accept_fast) begin
                    state_next = DONE;
                end
`endif
            end
            RUN: begin
                if (cnt_reg == LAST_ITER) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

    // ------------------------------------------------------------------
    // State, datapath and HI/LO registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= 6'd0;
            acc_reg    <= 64'd0;
            m_reg      <= 32'd0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            hi_reg     <= 32'd0;
            lo_reg     <= 32'd0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept_run) begin
                        cnt_reg    <= 6'd0;
                        is_div_reg <= op_div;
                        if (op_div) begin
                            acc_reg   <= {32'd0, a_mag};
                            m_reg     <= b_mag;
                            // A zero divisor keeps the all-ones quotient
                            // unnegated so lo reads 0xFFFFFFFF for DIV too.
                            neg_q_reg <= op_signed && (a[31] ^ b[31]) && (b != 32'd0);
                            neg_r_reg <= op_signed && a[31];
                        end else begin
                            acc_reg   <= {32'd0, b_mag};
                            m_reg     <= a_mag;
                            neg_q_reg <= op_signed && (a[31] ^ b[31]);
                            neg_r_reg <= 1'b0;
                        end
                    end
`ifdef MUL_DIV_UNIT_FAST_MULT_EN
                    else if (accept_fast) begin
                        hi_reg <= fast_prod[63:32];
                        lo_reg <= fast_prod[31:0];
                    end
`endif
                    else if (idle_start && op_mthi) begin
                        hi_reg <= a;
                    end else if (idle_start && op_mtlo) begin
                        lo_reg <= a;
                    end
                end
                RUN: begin
                    acc_reg <= acc_step;
                    cnt_reg <= cnt_reg + 6'd1;
                    if (cnt_reg == LAST_ITER) begin
                        hi_reg <= res_hi;
                        lo_reg <= res_lo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// ----------------------------------------------------------------------------
// tb_mul_div_unit
//
// Scoreboard bench for mul_div_unit. Each accepted arithmetic request pushes
// its expected {hi,lo} and the cycle in which done must appear; a monitor
// pops and compares on every done pulse. Direct checks cover reset, MTHI /
// MTLO, ignored requests and the abort-by-reset case.
// ----------------------------------------------------------------------------
module tb_mul_div_unit;

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  op;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mul_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .op    (op),
        .start (start),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [63:0] res;
        int          due;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: %h (cycle %0d)", tag, got, cyc);
        end
    endtask

    // Reference results from plain operators (64-bit signed divide avoids the
    // 32-bit overflow of 0x80000000 / -1).
    function automatic logic [63:0] model(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic signed [63:0] q;
        logic signed [63:0] r;
        logic [31:0]        uq;
        logic [31:0]        ur;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        case (o)
            OP_MULT:  return sx * sy;
            OP_MULTU: return {32'd0, x} * {32'd0, y};
            OP_DIV: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            OP_DIVU: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                uq = x / y;
                ur = x % y;
                return {ur, uq};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.tag, "_hilo"}, {hi, lo}, mon_e.res);
                check({mon_e.tag, "_cycle"}, 64'(cyc), 64'(mon_e.due));
            end
        end
    end

    // Issue one request; inputs change at the falling edge and are scrambled
    // after acceptance to show the running operation ignores them.
    task automatic run_op(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y,
                          input string tag, input bit expect_result);
        int lat;
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        lat   = 32;
`ifdef MUL_DIV_UNIT_FAST_MULT_EN
        if (o == OP_MULT || o == OP_MULTU) lat = 0;
`endif
        if (expect_result) sb.push_back('{res: model(o, x, y), due: cyc + 1 + lat, tag: tag});
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 6'($urandom);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    logic [5:0]  arith_ops [4] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;
    logic        exp_busy_mult;
    int          k;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        op    = 6'd0;
`ifdef MUL_DIV_UNIT_FAST_MULT_EN
        exp_busy_mult = 1'b0;
`else
        exp_busy_mult = 1'b1;
`endif
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;

        // Directed arithmetic vectors.
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5", 1'b1);
        check("busy_mult", 64'(busy), 64'(exp_busy_mult));
        wait_drain();
        check("busy_after_mult", 64'(busy), 64'd0);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b1);
        wait_drain();
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg7by2", 1'b1);
        check("busy_div", 64'(busy), 64'd1);
        wait_drain();
        run_op(OP_DIVU, 32'd100, 32'd7, "divu_100by7", 1'b1);
        wait_drain();
        run_op(OP_DIVU, 32'h0000_1234, 32'd0, "divu_by0", 1'b1);
        wait_drain();
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b1);
        wait_drain();
        run_op(OP_DIV, 32'h8000_0005, 32'd0, "div_neg_by0", 1'b1);
        wait_drain();

        // Second start while busy is dropped.
        run_op(OP_DIVU, 32'd1000, 32'd33, "divu_busy_ign", 1'b1);
        repeat (8) @(negedge clk);
        op    = OP_MULT;
        a     = 32'd3;
        b     = 32'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_still", 64'(busy), 64'd1);
        wait_drain();

        // MTHI / MTLO.
        @(negedge clk);
        prev_lo = lo;
        op      = OP_MTHI;
        a       = 32'hCAFE_F00D;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mthi_hilo", {hi, lo}, {32'hCAFE_F00D, prev_lo});
        check("mthi_busy", 64'(busy), 64'd0);
        op    = OP_MTLO;
        a     = 32'h1234_5678;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mtlo_hilo", {hi, lo}, {32'hCAFE_F00D, 32'h1234_5678});

        // Unknown funct code is ignored.
        op    = 6'b000000;
        a     = 32'h0000_FFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("badop_hilo", {hi, lo}, {32'hCAFE_F00D, 32'h1234_5678});
        check("badop_busy", 64'(busy), 64'd0);

        // Start during the DONE cycle is dropped.
        run_op(OP_DIVU, 32'd50, 32'd5, "divu_done_ign", 1'b1);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        check("done_seen", 64'(k < 50), 64'd1);
        op    = OP_DIV;
        a     = 32'd9;
        b     = 32'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_start_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        sb.delete();

        // Random arithmetic, including occasional zero divisors.
        for (int n = 0; n < 16; n++) begin
            run_op(arith_ops[$urandom_range(0, 3)], $urandom,
                   ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom), $sformatf("rand%0d", n), 1'b1);
            wait_drain();
        end

        // Abort by reset in the middle of a DIV.
        run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, "div_abort", 1'b0);
        repeat (13) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(done), 64'd0);

        // Reset wins over a simultaneous start.
        run_op(OP_MTHI, 32'h0000_0055, 32'd0, "mthi_pre", 1'b0);
        check("mthi_pre_hi", 64'(hi), 64'h55);
        op    = OP_MTHI;
        a     = 32'h0000_00AA;
        start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        op    = OP_DIV;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_hi", 64'(hi), 64'd0);
        check("rst_start_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
